trng_collector: RTL and testbench

Consumer end of the ring-oscillator TRNG bit stream.
- Drives the oscillator enable and discards a warm-up window.
- Samples the synchronized raw bit at a programmable rate and runs a repetition-count health test on the raw samples.
- Debiases the samples and packs them into words, which a bus reader takes through a valid/ready handshake.
- Sits between the trng block and the SoC peripheral register interface.

---
 rtl/trng_pkg.sv | 20 ++
 rtl/trng_rct.sv | 59 +++++
 rtl/trng_collector.sv | 188 ++++++++++++++++++
 tb/tb_trng_collector.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and sizing helpers for the TRNG collector (trng_collector, trng_rct).
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2
    } trng_state_t;

    localparam int DEF_WORD_WIDTH    = 32;
    localparam int DEF_SAMPLE_DIV    = 4;
    localparam int DEF_WARMUP_CYCLES = 256;
    localparam int DEF_RCT_CUTOFF    = 16;

    // Bits needed to hold the values 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test on raw TRNG samples; fail is sticky until clear.
module trng_rct
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sample_valid,
    input  logic sample,
    output logic fail
);

    localparam int CW = cnt_w(RCT_CUTOFF);

    logic [CW-1:0] run_q, run_d;
    logic          prev_q, prev_d;
    logic          fail_q, fail_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        run_d  = run_q;
        prev_d = prev_q;
        fail_d = fail_q;
        if (clear) begin
            run_d  = '0;
            prev_d = 1'b0;
            fail_d = 1'b0;
        end else if (sample_valid) begin
            prev_d = sample;
            // A zero count means no previous sample yet, so the run restarts.
            if (run_q == '0 || sample != prev_q) begin
                run_d = CW'(1);
            end else if (run_q != CW'(RCT_CUTOFF)) begin
                run_d = run_q + 1'b1;
            end
            if (run_d == CW'(RCT_CUTOFF)) begin
                fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            run_q  <= '0;
            prev_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= prev_d;
            fail_q <= fail_d;
        end
    end

    assign fail = fail_q;

endmodule

// File: rtl/trng_collector.sv
// TRNG consumer: warm-up, strobed sampling, RCT health test, optional debias, word packing.
// Define TRNG_COLLECTOR_VON_NEUMANN_EN to debias sample pairs; otherwise every sample is packed.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int RCT_CUTOFF    = DEF_RCT_CUTOFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  trng_en,
    input  logic                  raw_bit,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  health_fail
);

    localparam int WMW = cnt_w(WARMUP_CYCLES - 1);
    localparam int DVW = cnt_w(SAMPLE_DIV);
    localparam int BCW = cnt_w(WORD_WIDTH);

    trng_state_t           state_q, state_d;
    logic [WMW-1:0]        warm_q, warm_d;
    logic [DVW-1:0]        div_q, div_d;
    logic [BCW-1:0]        bits_q, bits_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    logic                  strobe;
    logic                  emit;
    logic                  emit_bit;
    logic                  drain;
    logic                  out_free;
    logic                  rct_clear;
    logic [WORD_WIDTH-1:0] shift_next;

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (!enable) begin
            state_d = IDLE;
            warm_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WARMUP;
                    warm_d  = '0;
                end
                WARMUP: begin
                    if (warm_q == WMW'(WARMUP_CYCLES - 1)) begin
                        state_d = COLLECT;
                        warm_d  = '0;
                    end else begin
                        warm_d = warm_q + 1'b1;
                    end
                end
                COLLECT: state_d = COLLECT;
                default: state_d = IDLE;
            endcase
        end
    end

    assign trng_en   = (state_q != IDLE);
    assign rct_clear = (state_q == IDLE) && enable;

    // The divider sits at 0 on entry to COLLECT, so the first strobe lands SAMPLE_DIV cycles in.
    assign strobe = enable && (state_q == COLLECT) && (div_q == DVW'(SAMPLE_DIV));

    always_comb begin
        div_d = '0;
        if (enable && state_q == COLLECT) begin
            div_d = strobe ? DVW'(1) : div_q + 1'b1;
        end
    end

`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
    logic pair_q, pair_d;
    logic first_q, first_d;

    always_comb begin
        pair_d  = pair_q;
        first_d = first_q;
        if (!enable) begin
            pair_d = 1'b0;
        end else if (strobe) begin
            pair_d = ~pair_q;
            if (!pair_q) begin
                first_d = raw_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pair_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            first_q <= first_d;
        end
    end

    // 10 emits 1 and 01 emits 0, i.e. the first sample of a differing pair.
    assign emit     = strobe && pair_q && (first_q != raw_bit);
    assign emit_bit = first_q;
`else
    assign emit     = strobe;
    assign emit_bit = raw_bit;
`endif

    assign drain      = valid_q && rd_ready;
    assign out_free   = (!valid_q || rd_ready) && !health_fail;
    assign shift_next = {shift_q[WORD_WIDTH-2:0], emit_bit};

    always_comb begin
        shift_d = shift_q;
        bits_d  = bits_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (!enable) begin
            bits_d  = '0;
            valid_d = 1'b0;
        end else if (bits_q == BCW'(WORD_WIDTH)) begin
            // A completed word is parked in the shift register; new bits are dropped.
            if (out_free) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                bits_d  = '0;
            end
        end else if (emit) begin
            shift_d = shift_next;
            if (bits_q == BCW'(WORD_WIDTH - 1)) begin
                if (out_free) begin
                    data_d  = shift_next;
                    valid_d = 1'b1;
                    bits_d  = '0;
                end else begin
                    bits_d = BCW'(WORD_WIDTH);
                end
            end else begin
                bits_d = bits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            warm_q  <= '0;
            div_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    trng_rct #(
        .RCT_CUTOFF(RCT_CUTOFF)
    ) u_rct (
        .clk         (clk),
        .reset       (reset),
        .clear       (rct_clear),
        .sample_valid(strobe),
        .sample      (raw_bit),
        .fail        (health_fail)
    );

    assign rd_valid = valid_q;
    assign rd_data  = data_q;

endmodule

// File: tb/tb_trng_collector.sv
// Self-checking bench for trng_collector: directed vector table, corner sequences, random run vs model.
module tb_trng_collector;

    localparam int W    = 8;
    localparam int DIV  = 1;
    localparam int WARM = 8;
    localparam int CUT  = 16;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         trng_en;
    logic         raw_bit;
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;
    logic         health_fail;

    int n_checks = 0;
    int n_errors = 0;

    trng_collector #(
        .WORD_WIDTH   (W),
        .SAMPLE_DIV   (DIV),
        .WARMUP_CYCLES(WARM),
        .RCT_CUTOFF   (CUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .trng_en    (trng_en),
        .raw_bit    (raw_bit),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time since enable, queues of pending pair samples and packed bits.
    bit           m_active;
    bit           m_valid;
    bit           m_fail;
    logic [W-1:0] m_data;
    int           m_t;
    int           m_run;
    bit           m_last;
    bit           m_bits[$];
    bit           m_pair[$];

    function automatic logic [W-1:0] pack_bits();
        logic [W-1:0] w = '0;
        foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
        return w;
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit raw, input bit rdy);
        bit strobe, emit, eb, free, drain, loaded;
        if (rst) begin
            m_active = 0; m_valid = 0; m_fail = 0; m_data = '0;
            m_t = 0; m_run = 0; m_last = 0;
            m_bits.delete(); m_pair.delete();
            return;
        end
        if (!en) begin
            m_active = 0; m_valid = 0; m_t = 0;
            m_bits.delete(); m_pair.delete();
            return;
        end
        if (!m_active) begin
            m_active = 1; m_t = 0; m_fail = 0; m_run = 0;
            return;
        end
        strobe = (m_t >= WARM + DIV) && (((m_t - WARM) % DIV) == 0);
        drain  = m_valid && rdy;
        free   = (!m_valid || rdy) && !m_fail;
        loaded = 0; emit = 0; eb = 0;
        if (strobe) begin
`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
            m_pair.push_back(raw);
            if (m_pair.size() == 2) begin
                if (m_pair[0] != m_pair[1]) begin
                    emit = 1; eb = m_pair[0];
                end
                m_pair.delete();
            end
`else
            emit = 1; eb = raw;
`endif
        end
        if (m_bits.size() == W) begin
            if (free) begin
                m_data = pack_bits(); m_bits.delete(); loaded = 1;
            end
        end else if (emit) begin
            m_bits.push_back(eb);
            if (m_bits.size() == W && free) begin
                m_data = pack_bits(); m_bits.delete(); loaded = 1;
            end
        end
        if (loaded) m_valid = 1;
        else if (drain) m_valid = 0;
        if (strobe) begin
            if (m_run == 0 || raw != m_last) m_run = 1;
            else m_run++;
            m_last = raw;
            if (m_run >= CUT) m_fail = 1;
        end
        m_t++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rb();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    task automatic tick(input bit rst, input bit en, input bit raw, input bit rdy);
        reset = rst; enable = en; raw_bit = raw; rd_ready = rdy;
        @(posedge clk);
        model_step(rst, en, raw, rdy);
        #1;
        check("trng_en", {31'd0, trng_en}, {31'd0, m_active});
        check("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
        check("rd_data", {24'd0, rd_data}, {24'd0, m_data});
        check("health_fail", {31'd0, health_fail}, {31'd0, m_fail});
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    // Enable, sit through warm-up with garbage raw bits, then the COLLECT entry cycle.
    task automatic start_collect();
        tick(0, 1, rb(), 0);
        check("trng_en_after_enable", {31'd0, trng_en}, 32'd1);
        repeat (WARM) tick(0, 1, rb(), 0);
        tick(0, 1, rb(), 0);
    endtask

    typedef struct {
        logic [31:0]  raw;
        int           n;
        logic [W-1:0] word;
    } vec_t;

    vec_t         vecs[3];
    logic [W-1:0] exp_first;
    logic [W-1:0] exp_second;
    bit           got;
    bit           stuck;

    initial begin
`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
        vecs[0] = '{raw: 32'h0000_9999, n: 16, word: 8'hAA};
        vecs[1] = '{raw: 32'h2D2D_2D2D, n: 32, word: 8'hAA};
        vecs[2] = '{raw: 32'h0000_5A65, n: 16, word: 8'h34};
`else
        vecs[0] = '{raw: 32'h0000_00B2, n: 8, word: 8'hB2};
        vecs[1] = '{raw: 32'h0000_005C, n: 8, word: 8'h5C};
        vecs[2] = '{raw: 32'h0000_0001, n: 8, word: 8'h01};
`endif
        reset = 1; enable = 0; raw_bit = 0; rd_ready = 0;

        do_reset();
        check("reset_trng_en", {31'd0, trng_en}, 32'd0);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rd_data", {24'd0, rd_data}, 32'd0);
        check("reset_health_fail", {31'd0, health_fail}, 32'd0);

        for (int v = 0; v < 3; v++) begin
            do_reset();
            start_collect();
            for (int i = vecs[v].n - 1; i >= 0; i--) begin
                tick(0, 1, vecs[v].raw[i], 0);
                if (i == 1) check("vec_valid_early", {31'd0, rd_valid}, 32'd0);
            end
            check("vec_valid", {31'd0, rd_valid}, 32'd1);
            check("vec_word", {24'd0, rd_data}, {24'd0, vecs[v].word});
        end

        // Backpressure: two words complete while the reader stalls.
        do_reset();
        start_collect();
        got = 0;
        exp_first = '0;
        for (int i = 0; i < 160; i++) begin
            tick(0, 1, rb(), 0);
            if (!got && m_valid) begin
                got = 1;
                exp_first = m_data;
            end
        end
        check("bp_first_valid", {31'd0, rd_valid}, 32'd1);
        check("bp_first_stable", {24'd0, rd_data}, {24'd0, exp_first});
        exp_second = pack_bits();
        tick(0, 1, rb(), 1);
        check("bp_second_valid", {31'd0, rd_valid}, 32'd1);
        check("bp_second_word", {24'd0, rd_data}, {24'd0, exp_second});
        tick(0, 1, rb(), 0);
        check("bp_second_hold", {24'd0, rd_data}, {24'd0, exp_second});

        // Stuck-at-1 source trips the repetition count on the CUT-th sample.
        do_reset();
        start_collect();
        for (int i = 1; i <= CUT; i++) begin
            tick(0, 1, 1'b1, 1);
            if (i == CUT - 1) check("rct_not_yet", {31'd0, health_fail}, 32'd0);
        end
        check("rct_tripped", {31'd0, health_fail}, 32'd1);
        repeat (3 * W) tick(0, 1, 1'b1, 1);
        check("rct_no_words", {31'd0, rd_valid}, 32'd0);
        tick(0, 0, 0, 1);
        check("rct_sticky", {31'd0, health_fail}, 32'd1);
        tick(0, 1, 0, 1);
        check("rct_cleared", {31'd0, health_fail}, 32'd0);
        check("rct_reenable_en", {31'd0, trng_en}, 32'd1);

        // Enable drop coinciding with a read handshake.
        do_reset();
        start_collect();
        for (int i = 0; i < 200 && !m_valid; i++) tick(0, 1, rb(), 0);
        check("drop_has_word", {31'd0, rd_valid}, 32'd1);
        tick(0, 0, rb(), 1);
        check("drop_valid", {31'd0, rd_valid}, 32'd0);
        check("drop_trng_en", {31'd0, trng_en}, 32'd0);
        start_collect();
        repeat (80) tick(0, 1, rb(), $urandom_range(0, 2) == 0);

        // Randomized run with occasional stuck source, enable drops and resets.
        stuck = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) stuck = ~stuck;
            tick($urandom_range(0, 599) == 0,
                 $urandom_range(0, 249) != 0,
                 stuck ? 1'b1 : rb(),
                 $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
